mips_lsu: RTL and testbench

MIPS_LSU -- requirements
Module: mips_lsu

---
 rtl/mips_lsu.sv | 203 ++++++++++++++++++++
 tb/tb_mips_lsu.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_lsu.sv
// mips_lsu: single-outstanding MIPS load/store unit.
// IDLE accepts, WAIT runs the memory handshake, RESP pulses the result.
module mips_lsu #(
  parameter int ADDR_W     = 18,
  parameter int BIG_ENDIAN = 0,
  parameter int TIMEOUT    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [2:0]        op_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       rdata_q;
  logic [4:0]        rrd_q;
  logic              err_q;

  logic        req_mis;
  logic        is_load;
  logic        tmo;
  logic [1:0]  blane;
  logic        hsel;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_val;
  logic [3:0]  be_v;
  logic [31:0] wd_v;
  logic        unused_req;

  assign unused_req = ^req_addr;

  // Misalignment of the incoming request, judged at acceptance.
  always_comb begin
    req_mis = 1'b0;
    unique case (req_op)
      OP_LH, OP_LHU, OP_SH: req_mis = req_addr[0];
      OP_LW, OP_SW:         req_mis = |req_addr[1:0];
      default:              req_mis = 1'b0;
    endcase
  end

  assign is_load = (op_q <= OP_LW);

  // Timeout fires on the last permitted WAIT cycle without an ack.
  always_comb begin
    tmo = 1'b0;
    if (TIMEOUT > 0)
      tmo = ~mem_ack & (32'(cnt_q) == 32'(TIMEOUT - 1));
  end

  // Lane steering for load extraction and store enables/data.
  always_comb begin
    blane    = (BIG_ENDIAN != 0) ? ~addr_q[1:0] : addr_q[1:0];
    hsel     = (BIG_ENDIAN != 0) ? ~addr_q[1] : addr_q[1];
    rbyte    = 8'(mem_rdata >> {blane, 3'b000});
    rhalf    = hsel ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = '0;
    be_v     = 4'b1111;
    wd_v     = wdata_q;
    unique case (op_q)
      OP_LB:  load_val = {{24{rbyte[7]}}, rbyte};
      OP_LBU: load_val = {24'b0, rbyte};
      OP_LH:  load_val = {{16{rhalf[15]}}, rhalf};
      OP_LHU: load_val = {16'b0, rhalf};
      OP_LW:  load_val = mem_rdata;
      OP_SB: begin
        be_v = 4'b0001 << blane;
        wd_v = {4{wdata_q[7:0]}};
      end
      OP_SH: begin
        be_v = hsel ? 4'b1100 : 4'b0011;
        wd_v = {2{wdata_q[15:0]}};
      end
      OP_SW:  wd_v = wdata_q;
      default: load_val = '0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid)
          state_d = req_mis ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack || tmo)
          state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Request capture, timeout count and response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rrd_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr[ADDR_W+1:0];
            wdata_q <= req_wdata;
            rd_q    <= req_rd;
            cnt_q   <= '0;
            rdata_q <= '0;
            rrd_q   <= '0;
            err_q   <= req_mis;
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            rdata_q <= is_load ? load_val : '0;
            rrd_q   <= is_load ? rd_q : '0;
            err_q   <= 1'b0;
          end else if (tmo) begin
            err_q   <= 1'b1;
          end else if (TIMEOUT > 0) begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          rdata_q <= '0;
          rrd_q   <= '0;
          err_q   <= 1'b0;
        end
        default: begin
          err_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign mem_req    = (state_q == S_WAIT);
  assign mem_we     = mem_req & ~is_load;
  assign mem_be     = mem_req ? be_v : 4'b0000;
  assign mem_addr   = addr_q[ADDR_W+1:2];
  assign mem_wdata  = wd_v;
  assign resp_valid = (state_q == S_RESP);
  assign resp_data  = resp_valid ? rdata_q : '0;
  assign resp_rd    = resp_valid ? rrd_q : '0;
  assign resp_err   = resp_valid & err_q;

endmodule

// File: tb/tb_mips_lsu.sv
// tb_mips_lsu: scoreboard bench, one little- and one big-endian LSU
// driven in lockstep from the same stimulus.
module tb_mips_lsu;

  localparam int AW  = 18;
  localparam int TMO = 4;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } resp_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [31:0]   wd;
  } memx_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic [1:0]  req_ready;
  logic [1:0]  resp_valid;
  logic [31:0] resp_data [2];
  logic [4:0]  resp_rd [2];
  logic [1:0]  resp_err;
  logic [1:0]  mem_req;
  logic [1:0]  mem_we;
  logic [AW-1:0] mem_addr [2];
  logic [3:0]  mem_be [2];
  logic [31:0] mem_wdata [2];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit exp_rdy = 1'b0;
  bit exp_mreq = 1'b0;
  bit exp_rv = 1'b0;

  resp_t rq0[$];
  resp_t rq1[$];
  memx_t mq0[$];
  memx_t mq1[$];

  always #5 clk = ~clk;

  mips_lsu #(.ADDR_W(AW), .BIG_ENDIAN(0), .TIMEOUT(TMO)) u_le (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid[0]), .resp_data(resp_data[0]),
    .resp_rd(resp_rd[0]), .resp_err(resp_err[0]),
    .mem_req(mem_req[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_be(mem_be[0]),
    .mem_wdata(mem_wdata[0]),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  mips_lsu #(.ADDR_W(AW), .BIG_ENDIAN(1), .TIMEOUT(TMO)) u_be (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid[1]), .resp_data(resp_data[1]),
    .resp_rd(resp_rd[1]), .resp_err(resp_err[1]),
    .mem_req(mem_req[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_be(mem_be[1]),
    .mem_wdata(mem_wdata[1]),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  function automatic int size_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd5: return 1;
      3'd2, 3'd3, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic int lane_of(input int big, input int k);
    return (big != 0) ? 3 - k : k;
  endfunction

  function automatic bit misal(input logic [2:0] op, input logic [31:0] addr);
    return (int'(addr[1:0]) % size_of(op)) != 0;
  endfunction

  function automatic resp_t exp_resp(input int big, input logic [2:0] op,
                                     input logic [31:0] addr,
                                     input logic [31:0] rdata,
                                     input logic [4:0] rd, input bit tmo);
    resp_t r;
    int sz;
    int off;
    logic [31:0] v;
    logic [31:0] b;
    r = '0;
    sz = size_of(op);
    off = int'(addr[1:0]);
    if (misal(op, addr) || tmo) begin
      r.err = 1'b1;
      return r;
    end
    if (op >= 3'd5) return r;
    v = '0;
    for (int i = 0; i < sz; i++) begin
      b = (rdata >> (8 * lane_of(big, off + i))) & 32'hFF;
      if (big != 0) v = (v << 8) | b;
      else          v = v | (b << (8 * i));
    end
    if ((op == 3'd0 || op == 3'd2) && v[8 * sz - 1])
      v = v | (32'hFFFF_FFFF << (8 * sz));
    r.data = v;
    r.rd = rd;
    return r;
  endfunction

  function automatic memx_t exp_mem(input int big, input logic [2:0] op,
                                    input logic [31:0] addr,
                                    input logic [31:0] wdata);
    memx_t m;
    int sz;
    int off;
    logic [31:0] mask;
    sz = size_of(op);
    off = int'(addr[1:0]);
    m.we = (op >= 3'd5);
    m.addr = addr[AW+1:2];
    m.be = 4'hF;
    m.wd = '0;
    if (m.we) begin
      m.be = '0;
      mask = 32'hFFFF_FFFF >> (32 - 8 * sz);
      for (int i = 0; i < sz; i++) m.be[lane_of(big, off + i)] = 1'b1;
      for (int j = 0; j < 4 / sz; j++)
        m.wd = m.wd | ((wdata & mask) << (8 * sz * j));
    end
    return m;
  endfunction

  task automatic chk(input string name, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t",
               name, d, act, exp, $time);
    end
  endtask

  task automatic mon(input int d);
    memx_t m;
    resp_t e;
    bit empty;
    chk("req_ready", d, 32'(req_ready[d]), 32'(exp_rdy));
    chk("mem_req", d, 32'(mem_req[d]), 32'(exp_mreq));
    if (mem_req[d]) begin
      empty = (d == 0) ? (mq0.size() == 0) : (mq1.size() == 0);
      if (empty) begin
        chk("mem_unexpected", d, 32'(1), 32'(0));
      end else begin
        m = (d == 0) ? mq0[0] : mq1[0];
        chk("mem_we", d, 32'(mem_we[d]), 32'(m.we));
        chk("mem_addr", d, 32'(mem_addr[d]), 32'(m.addr));
        chk("mem_be", d, 32'(mem_be[d]), 32'(m.be));
        if (m.we) chk("mem_wdata", d, mem_wdata[d], m.wd);
      end
    end
    chk("resp_valid", d, 32'(resp_valid[d]), 32'(exp_rv));
    if (resp_valid[d]) begin
      empty = (d == 0) ? (rq0.size() == 0) : (rq1.size() == 0);
      if (empty) begin
        chk("resp_unexpected", d, 32'(1), 32'(0));
      end else begin
        e = (d == 0) ? rq0.pop_front() : rq1.pop_front();
        chk("resp_data", d, resp_data[d], e.data);
        chk("resp_rd", d, 32'(resp_rd[d]), 32'(e.rd));
        chk("resp_err", d, 32'(resp_err[d]), 32'(e.err));
      end
    end else begin
      chk("idle_resp", d,
          resp_data[d] | 32'(resp_rd[d]) | 32'(resp_err[d]), 32'(0));
    end
  endtask

  // Monitor: samples both DUTs on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) mon(d);
      end
    end
  end

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] rdata, input int dly,
                        input int gd, input logic [31:0] gdata,
                        input logic [3:0] gbe, input logic [31:0] gwd);
    resp_t e;
    memx_t m;
    bit mis;
    bit tmo;
    mis = misal(op, addr);
    tmo = !mis && (dly > TMO - 1);
    for (int d = 0; d < 2; d++) begin
      e = exp_resp(d, op, addr, rdata, rd, tmo);
      if (gd == d) e.data = gdata;
      if (d == 0) rq0.push_back(e);
      else        rq1.push_back(e);
      if (!mis) begin
        m = exp_mem(d, op, addr, wdata);
        if (gd == d && gbe != 4'h0) begin
          m.be = gbe;
          m.wd = gwd;
        end
        if (d == 0) mq0.push_back(m);
        else        mq1.push_back(m);
      end
    end
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    req_wdata = wdata;
    req_rd = rd;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op = 3'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    req_rd = 5'($urandom);
    exp_rdy = 1'b0;
    if (mis) begin
      exp_rv = 1'b1;
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end else begin
      exp_mreq = 1'b1;
      for (int c = 0; c < 64; c++) begin
        mem_ack = (c == dly);
        mem_rdata = (c == dly) ? rdata : $urandom;
        @(posedge clk); #1;
        if (c == dly || c == TMO - 1) break;
      end
      mq0.delete();
      mq1.delete();
      exp_mreq = 1'b0;
      exp_rv = 1'b1;
      mem_ack = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    exp_rv = 1'b0;
    exp_rdy = 1'b1;
    mem_ack = 1'b0;
  endtask

  task automatic reset_abort();
    for (int d = 0; d < 2; d++) begin
      if (d == 0) mq0.push_back(exp_mem(d, 3'd4, 32'h20, 32'h0));
      else        mq1.push_back(exp_mem(d, 3'd4, 32'h20, 32'h0));
    end
    req_valid = 1'b1;
    req_op = 3'd4;
    req_addr = 32'h20;
    mem_ack = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_rdy = 1'b0;
    exp_mreq = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mq0.delete();
    mq1.delete();
    exp_mreq = 1'b0;
    exp_rdy = 1'b1;
    mem_ack = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  // Stimulus: reset, directed cases, then randomized traffic.
  initial begin
    logic [2:0]  op;
    logic [31:0] addr;
    reset = 1'b1;
    req_valid = 1'b1;
    req_op = 3'd7;
    req_addr = 32'h0;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    exp_rdy = 1'b1;
    exp_mreq = 1'b0;
    exp_rv = 1'b0;
    mon_en = 1'b1;
    repeat (2) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("rst_mem_we", d, 32'(mem_we[d]), 32'(0));
        chk("rst_mem_be", d, 32'(mem_be[d]), 32'(0));
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    req_valid = 1'b0;
    mem_ack = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end

    do_req(3'd0, 32'h103, 32'h0, 5'd3, 32'h80FF1234, 3,
           0, 32'hFFFFFF80, 4'h0, 32'h0);
    do_req(3'd3, 32'h2, 32'h0, 5'd4, 32'h1234ABCD, 0,
           1, 32'h0000ABCD, 4'h0, 32'h0);
    do_req(3'd2, 32'h2, 32'h0, 5'd5, 32'h1234ABCD, 1,
           1, 32'hFFFFABCD, 4'h0, 32'h0);
    do_req(3'd5, 32'h5, 32'h000000A7, 5'd6, 32'h0, 0,
           0, 32'h0, 4'b0010, 32'hA7A7A7A7);
    do_req(3'd6, 32'h6, 32'h1234BEEF, 5'd7, 32'h0, 2,
           0, 32'h0, 4'b1100, 32'hBEEFBEEF);
    do_req(3'd4, 32'h6, 32'h0, 5'd8, 32'h0, 0,
           -1, 32'h0, 4'h0, 32'h0);
    do_req(3'd4, 32'h10, 32'h0, 5'd9, 32'h55AA55AA, 9,
           -1, 32'h0, 4'h0, 32'h0);
    do_req(3'd4, 32'h10, 32'h0, 5'd9, 32'h55AA55AA, 3,
           -1, 32'h0, 4'h0, 32'h0);
    reset_abort();

    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom_range(0, 7));
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      do_req(op, addr, $urandom, 5'($urandom), $urandom,
             $urandom_range(0, 5), -1, 32'h0, 4'h0, 32'h0);
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("drain", 0, 32'(rq0.size()), 32'(0));
    chk("drain", 1, 32'(rq1.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
